// File: rtl/icache_2way.sv
// Two-way set-associative read-only instruction cache with per-set LRU,
// whole-cache single-cycle flush and saturating hit/miss counters.
module icache_2way #(
   parameter int SET_BITS = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             proc_reset_n,
   input  logic             proc_read,
   input  logic             proc_write,
   input  logic [29:0]      proc_addr,
   input  logic [31:0]      proc_wdata,
   input  logic             flush,
   output logic             proc_stall,
   output logic [31:0]      proc_rdata,
   output logic             mem_read,
   output logic             mem_write,
   output logic [27:0]      mem_addr,
   input  logic [127:0]     mem_rdata,
   input  logic             mem_ready,
   output logic [127:0]     mem_wdata,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int NSETS = 1 << SET_BITS;
   localparam int TAG_W = 28 - SET_BITS;

   typedef enum logic {S_IDLE, S_READ_MEM} state_t;

   state_t              r_state;
   logic [NSETS-1:0]    r_valid0, r_valid1, r_lru;
   logic [TAG_W-1:0]    r_tag0  [NSETS];
   logic [TAG_W-1:0]    r_tag1  [NSETS];
   logic [127:0]        r_data0 [NSETS];
   logic [127:0]        r_data1 [NSETS];
   logic                r_flush_pending;
   logic                r_mem_ready_q;
   logic [127:0]        r_mem_rdata_q;
   logic [CNT_W-1:0]    r_hit_cnt, r_miss_cnt;

   logic [SET_BITS-1:0] w_index;
   logic [TAG_W-1:0]    w_tag;
   logic [1:0]          w_word;
   logic                w_hit0, w_hit1, w_victim;
   logic                w_do_hit, w_do_miss, w_do_flush, w_do_fill;
   logic                w_stall, w_mem_read;
   logic [27:0]         w_mem_addr;
   logic [31:0]         w_rdata;
   logic                w_unused;

   function automatic logic [31:0] f_word(input logic [127:0] line, input logic [1:0] w);
      logic [31:0] v;
      case (w)
         2'd0:    v = line[31:0];
         2'd1:    v = line[63:32];
         2'd2:    v = line[95:64];
         default: v = line[127:96];
      endcase
      return v;
   endfunction

   assign w_index  = proc_addr[1+SET_BITS:2];
   assign w_tag    = proc_addr[29:2+SET_BITS];
   assign w_word   = proc_addr[1:0];
   assign w_hit0   = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
   assign w_hit1   = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
   // Fill an empty way first (way 0 preferred); LRU only decides between two valid ways.
   assign w_victim = !r_valid0[w_index] ? 1'b0 :
                     !r_valid1[w_index] ? 1'b1 : r_lru[w_index];
   assign w_unused = ^{proc_write, proc_wdata};

   always_comb begin
      w_stall    = 1'b0;
      w_mem_read = 1'b0;
      w_mem_addr = '0;
      w_rdata    = '0;
      w_do_hit   = 1'b0;
      w_do_miss  = 1'b0;
      w_do_flush = 1'b0;
      w_do_fill  = 1'b0;
      if (r_state == S_IDLE) begin
         if (flush || r_flush_pending) begin
            w_stall    = 1'b1;
            w_do_flush = 1'b1;
         end else if (proc_read && (w_hit0 || w_hit1)) begin
            w_do_hit = 1'b1;
            w_rdata  = f_word(w_hit1 ? r_data1[w_index] : r_data0[w_index], w_word);
         end else if (proc_read) begin
            w_stall    = 1'b1;
            w_mem_read = 1'b1;
            w_mem_addr = proc_addr[29:2];
            w_do_miss  = 1'b1;
         end
      end else if (!r_mem_ready_q) begin
         w_stall    = 1'b1;
         w_mem_read = 1'b1;
         w_mem_addr = proc_addr[29:2];
      end else begin
         w_do_fill = 1'b1;
         w_rdata   = f_word(r_mem_rdata_q, w_word);
      end
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         r_state         <= S_IDLE;
         r_valid0        <= '0;
         r_valid1        <= '0;
         r_lru           <= '0;
         r_flush_pending <= 1'b0;
         r_mem_ready_q   <= 1'b0;
         r_mem_rdata_q   <= '0;
         r_hit_cnt       <= '0;
         r_miss_cnt      <= '0;
      end else begin
         r_mem_ready_q <= mem_ready;
         r_mem_rdata_q <= mem_rdata;
         if (w_do_flush) begin
            r_valid0        <= '0;
            r_valid1        <= '0;
            r_lru           <= '0;
            r_flush_pending <= 1'b0;
         end
         // A flush seen mid-fill is deferred until the fill has retired.
         if (r_state == S_READ_MEM && flush) r_flush_pending <= 1'b1;
         if (w_do_hit) begin
            r_lru[w_index] <= ~w_hit1;
            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
         end
         if (w_do_miss) begin
            r_state <= S_READ_MEM;
            if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
         end
         if (w_do_fill) begin
            r_state        <= S_IDLE;
            r_lru[w_index] <= ~w_victim;
            if (w_victim) r_valid1[w_index] <= 1'b1;
            else          r_valid0[w_index] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_fill) begin
         if (w_victim) begin
            r_tag1[w_index]  <= w_tag;
            r_data1[w_index] <= r_mem_rdata_q;
         end else begin
            r_tag0[w_index]  <= w_tag;
            r_data0[w_index] <= r_mem_rdata_q;
         end
      end
   end

   assign proc_stall = w_stall;
   assign proc_rdata = w_rdata;
   assign mem_read   = w_mem_read;
   assign mem_addr   = w_mem_addr;
   assign mem_write  = 1'b0;
   assign mem_wdata  = '0;
   assign hit_cnt    = r_hit_cnt;
   assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_icache_2way.sv
// Scoreboard bench for icache_2way: the driver queues expected fetch data,
// a negedge monitor pops and compares whenever a fetch completes unstalled.
module tb_icache_2way;
   localparam int SET_BITS = 3;
   localparam int CNT_W    = 4;

   logic             clk = 1'b0;
   logic             proc_reset_n;
   logic             proc_read, proc_write, flush, mem_ready;
   logic [29:0]      proc_addr;
   logic [31:0]      proc_wdata;
   logic [127:0]     mem_rdata;
   logic             proc_stall, mem_read, mem_write;
   logic [31:0]      proc_rdata;
   logic [27:0]      mem_addr;
   logic [127:0]     mem_wdata;
   logic [CNT_W-1:0] hit_cnt, miss_cnt;

   int               n_checks = 0;
   int               n_err    = 0;
   int               exp_h    = 0;
   int               exp_m    = 0;
   logic [31:0]      q [$];

   icache_2way #(.SET_BITS(SET_BITS), .CNT_W(CNT_W)) dut (
      .clk(clk), .proc_reset_n(proc_reset_n), .proc_read(proc_read),
      .proc_write(proc_write), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
      .flush(flush), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_wdata(mem_wdata),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   // Memory contents: every word is unique to its line address and word slot.
   function automatic logic [31:0] mword(input logic [27:0] la, input logic [1:0] w);
      return {la[25:0], w, 4'hA};
   endfunction

   function automatic logic [127:0] mline(input logic [27:0] la);
      return {mword(la, 2'd3), mword(la, 2'd2), mword(la, 2'd1), mword(la, 2'd0)};
   endfunction

   function automatic logic [29:0] caddr(input int tag);
      return 30'(tag * 32 + 8);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (proc_reset_n && proc_read && !proc_stall) begin
         if (q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_rdata: got %0h expected no completion", proc_rdata);
         end else begin
            chk("rdata", {96'b0, proc_rdata}, {96'b0, q.pop_front()});
         end
      end
   end

   task automatic do_read(input logic [29:0] a, input bit hit, input int dly, input bit fl);
      q.push_back(mword(a[29:2], a[1:0]));
      proc_read = 1'b1;
      proc_addr = a;
      @(negedge clk);
      if (hit) begin
         chk("hit_stall", proc_stall, 0);
         chk("hit_mem_read", mem_read, 0);
         if (exp_h < 15) exp_h++;
      end else begin
         chk("miss_stall", proc_stall, 1);
         chk("miss_mem_read", mem_read, 1);
         chk("miss_mem_addr", mem_addr, a[29:2]);
         if (exp_m < 15) exp_m++;
         for (int c = 0; c < dly; c++) begin
            @(posedge clk);
            #1 flush = fl && (c == 0);
         end
         flush = 1'b0;
         @(negedge clk);
         chk("fill_wait_stall", proc_stall, 1);
         chk("fill_wait_mem_read", mem_read, 1);
         mem_ready = 1'b1;
         mem_rdata = mline(a[29:2]);
         @(posedge clk);
         #1 mem_ready = 1'b0;
         mem_rdata = '0;
         @(negedge clk);
         chk("fill_stall_low", proc_stall, 0);
         chk("fill_mem_read_low", mem_read, 0);
         if (fl) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("flush_pending_stall", proc_stall, 1);
            chk("flush_pending_mem_read", mem_read, 0);
         end
      end
      @(posedge clk);
      #1 proc_read = 1'b0;
   endtask

   task automatic chk_cnt(input string nm);
      chk({nm, "_hit_cnt"}, hit_cnt, exp_h);
      chk({nm, "_miss_cnt"}, miss_cnt, exp_m);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      proc_reset_n = 1'b0;
      proc_read    = 1'b0;
      proc_write   = 1'b0;
      proc_addr    = '0;
      proc_wdata   = 32'hDEAD_BEEF;
      flush        = 1'b0;
      mem_ready    = 1'b0;
      mem_rdata    = '0;
      #22 proc_reset_n = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_stall", proc_stall, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", proc_rdata, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk_cnt("rst");
      @(posedge clk);
      #1;

      // Basic miss then hit: index 4, word 0, line address 0x4
      do_read(30'h10, 0, 3, 0);
      do_read(30'h10, 1, 0, 0);
      chk("basic_hit_cnt_is_1", hit_cnt, 1);
      chk("basic_miss_cnt_is_1", miss_cnt, 1);

      for (int w = 1; w < 4; w++) do_read(30'h10 | 30'(w), 1, 0, 0);

      // Conflicts in set 2 exercising LRU victim choice
      do_read(caddr(1), 0, 2, 0);
      do_read(caddr(2), 0, 1, 0);
      do_read(caddr(1), 1, 0, 0);
      do_read(caddr(3), 0, 2, 0);
      do_read(caddr(1), 1, 0, 0);
      do_read(caddr(3), 1, 0, 0);
      do_read(caddr(2), 0, 1, 0);
      do_read(caddr(1), 0, 1, 0);
      chk_cnt("conflict");

      // Flush in an IDLE cycle competing with a hit
      do_read(30'h10, 1, 0, 0);
      proc_read = 1'b1;
      proc_addr = 30'h12;
      flush     = 1'b1;
      @(negedge clk);
      chk("flush_idle_stall", proc_stall, 1);
      chk("flush_idle_mem_read", mem_read, 0);
      @(posedge clk);
      #1 flush = 1'b0;
      proc_read = 1'b0;
      chk_cnt("after_flush");
      do_read(30'h10, 0, 1, 0);
      do_read(caddr(2), 0, 2, 0);

      // Flush raised while a fill is outstanding
      do_read(30'h200, 0, 3, 1);
      do_read(30'h200, 0, 1, 0);
      chk_cnt("flush_mid_fill");

      repeat (20) do_read(30'h201, 1, 0, 0);
      chk("sat_hit_cnt", hit_cnt, 4'hF);
      chk_cnt("sat");

      // Reset asserted during a fill
      proc_read = 1'b1;
      proc_addr = 30'h3000;
      @(negedge clk);
      chk("rstfill_mem_read", mem_read, 1);
      @(posedge clk);
      #2;
      chk("rstfill_readmem_mem_read", mem_read, 1);
      proc_reset_n = 1'b0;
      proc_read    = 1'b0;
      #1;
      chk("rstfill_async_mem_read", mem_read, 0);
      exp_h = 0;
      exp_m = 0;
      @(posedge clk);
      #1 proc_reset_n = 1'b1;
      @(posedge clk);
      #1 mem_ready = 1'b1;
      mem_rdata = mline(28'hC00);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      mem_rdata = '0;
      @(negedge clk);
      chk("stale_ready_mem_read", mem_read, 0);
      chk("stale_ready_stall", proc_stall, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_cnt("post_reset");
      do_read(30'h3000, 0, 2, 0);
      do_read(30'h3000, 1, 0, 0);
      chk_cnt("final");

      @(posedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
